// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the PC, drives the instruction ROM and registers
// the fetched word with its PC into the IF/ID outputs for decode.
module inst_fetch #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] START_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_if,
    input  logic              stall_id,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] new_pc_i,
    output logic              rom_ce,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_inst,
    output logic [ADDR_W-1:0] id_pc,
    output logic [DATA_W-1:0] id_inst
);

    logic [ADDR_W-1:0] pc;
    logic              ce;
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_target;
    logic [ADDR_W-1:0] branch_target_al;
    logic [ADDR_W-1:0] new_pc_al;

    // Redirect addresses are always forced onto a word boundary.
    assign branch_target_al = {branch_target_i[ADDR_W-1:2], 2'b00};
    assign new_pc_al        = {new_pc_i[ADDR_W-1:2], 2'b00};

    assign rom_addr = pc;
    assign rom_ce   = ce;

    // A branch seen during a stall is parked in pend_target and taken on release.
    always_ff @(posedge clk) begin
        if (rst) begin
            ce          <= 1'b0;
            pc          <= START_PC;
            pend_valid  <= 1'b0;
            pend_target <= '0;
        end else begin
            ce <= 1'b1;
            if (ce) begin
                if (flush_i) begin
                    pc         <= new_pc_al;
                    pend_valid <= 1'b0;
                end else if (stall_if) begin
                    if (branch_flag_i) begin
                        pend_valid  <= 1'b1;
                        pend_target <= branch_target_al;
                    end
                end else if (branch_flag_i) begin
                    pc         <= branch_target_al;
                    pend_valid <= 1'b0;
                end else if (pend_valid) begin
                    pc         <= pend_target;
                    pend_valid <= 1'b0;
                end else begin
                    pc <= pc + ADDR_W'(4);
                end
            end
        end
    end

    // IF/ID register: a stalled IF feeding a running ID injects a NOP bubble.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            id_pc   <= '0;
            id_inst <= '0;
        end else if (stall_if && !stall_id) begin
            id_pc   <= '0;
            id_inst <= '0;
        end else if (!stall_if) begin
            id_pc   <= pc;
            id_inst <= ce ? rom_inst : '0;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: sequential fetch, delay-slot branch, stalls,
// pending branch, flush, address wrap and reset with a branch pending.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_if;
    logic        stall_id;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        flush_i;
    logic [31:0] new_pc_i;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic [31:0] id_pc;
    logic [31:0] id_inst;

    int checks = 0;
    int errors = 0;

    inst_fetch #(.ADDR_W(32), .DATA_W(32), .START_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .stall_if(stall_if), .stall_id(stall_id),
        .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
        .flush_i(flush_i), .new_pc_i(new_pc_i), .rom_ce(rom_ce),
        .rom_addr(rom_addr), .rom_inst(rom_inst), .id_pc(id_pc), .id_inst(id_inst)
    );

    always #5 clk = ~clk;

    // ROM word k holds 0x1000_0000 + k.
    assign rom_inst = 32'h1000_0000 + (rom_addr >> 2);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; stall_if = 1'b0; stall_id = 1'b0; branch_flag_i = 1'b0;
        branch_target_i = '0; flush_i = 1'b0; new_pc_i = '0;
        step(); step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; stall_if = 1'b0; stall_id = 1'b0; branch_flag_i = 1'b0;
        branch_target_i = '0; flush_i = 1'b0; new_pc_i = '0;
        step(); step();
        checks++; if (rom_ce !== 1'b0) begin errors++; $display("[TB] FAIL reset_ce got %b exp 0", rom_ce); end
        checks++; if (rom_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_addr got %h exp 00000000", rom_addr); end
        checks++; if (id_pc !== 32'h0 || id_inst !== 32'h0) begin errors++; $display("[TB] FAIL reset_id got %h/%h exp 0/0", id_pc, id_inst); end
        rst = 1'b0;
        step();
        checks++; if (rom_ce !== 1'b1 || rom_addr !== 32'h0) begin errors++; $display("[TB] FAIL first_fetch got ce=%b addr=%h exp ce=1 addr=00000000", rom_ce, rom_addr); end
        checks++; if (id_inst !== 32'h0) begin errors++; $display("[TB] FAIL first_edge_inst got %h exp 00000000", id_inst); end
    endtask

    task automatic test_sequential();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (id_pc !== 32'(4 * k) || id_inst !== 32'h1000_0000 + 32'(k)) begin
                errors++;
                $display("[TB] FAIL seq_%0d got %h/%h exp %h/%h", k, id_pc, id_inst, 32'(4 * k), 32'h1000_0000 + 32'(k));
            end
        end
    endtask

    task automatic test_branch();
        do_reset();
        step(); step(); step();
        checks++; if (id_pc !== 32'h8 || rom_addr !== 32'hC) begin errors++; $display("[TB] FAIL br_pre got %h/%h exp 00000008/0000000c", id_pc, rom_addr); end
        branch_flag_i = 1'b1; branch_target_i = 32'h40;
        step();
        branch_flag_i = 1'b0;
        checks++; if (id_pc !== 32'hC || id_inst !== 32'h1000_0003) begin errors++; $display("[TB] FAIL br_delay_slot got %h/%h exp 0000000c/10000003", id_pc, id_inst); end
        checks++; if (rom_addr !== 32'h40) begin errors++; $display("[TB] FAIL br_target_addr got %h exp 00000040", rom_addr); end
        step();
        checks++; if (id_pc !== 32'h40 || id_inst !== 32'h1000_0010) begin errors++; $display("[TB] FAIL br_target_id got %h/%h exp 00000040/10000010", id_pc, id_inst); end
        step();
        checks++; if (id_pc !== 32'h44) begin errors++; $display("[TB] FAIL br_after got %h exp 00000044", id_pc); end
    endtask

    task automatic test_stall();
        do_reset();
        for (int k = 0; k < 4; k++) step();
        stall_if = 1'b1; stall_id = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (rom_addr !== 32'h10 || id_pc !== 32'hC || id_inst !== 32'h1000_0003) begin
                errors++;
                $display("[TB] FAIL stall_hold_%0d got %h %h/%h exp 00000010 0000000c/10000003", k, rom_addr, id_pc, id_inst);
            end
        end
        stall_id = 1'b0;
        step();
        checks++; if (id_pc !== 32'h0 || id_inst !== 32'h0 || rom_addr !== 32'h10) begin errors++; $display("[TB] FAIL stall_bubble got %h %h/%h exp 00000010 0/0", rom_addr, id_pc, id_inst); end
        stall_if = 1'b0;
        step();
        checks++; if (id_pc !== 32'h10 || id_inst !== 32'h1000_0004 || rom_addr !== 32'h14) begin errors++; $display("[TB] FAIL stall_resume got %h %h/%h exp 00000014 00000010/10000004", rom_addr, id_pc, id_inst); end
    endtask

    task automatic test_branch_during_stall();
        do_reset();
        for (int k = 0; k < 4; k++) step();
        stall_if = 1'b1; stall_id = 1'b1; branch_flag_i = 1'b1; branch_target_i = 32'h80;
        step();
        branch_flag_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++; if (rom_addr !== 32'h10) begin errors++; $display("[TB] FAIL pend_hold_%0d got %h exp 00000010", k, rom_addr); end
            if (k < 2) step();
        end
        stall_if = 1'b0; stall_id = 1'b0;
        step();
        checks++; if (rom_addr !== 32'h80 || id_pc !== 32'h10) begin errors++; $display("[TB] FAIL pend_release got %h/%h exp 00000080/00000010", rom_addr, id_pc); end
        step();
        checks++; if (id_pc !== 32'h80 || id_inst !== 32'h1000_0020 || rom_addr !== 32'h84) begin errors++; $display("[TB] FAIL pend_target got %h %h/%h exp 00000084 00000080/10000020", rom_addr, id_pc, id_inst); end
    endtask

    task automatic test_flush();
        do_reset();
        for (int k = 0; k < 4; k++) step();
        stall_if = 1'b1; stall_id = 1'b1; branch_flag_i = 1'b1; branch_target_i = 32'h80;
        step();
        branch_flag_i = 1'b0; flush_i = 1'b1; new_pc_i = 32'h20;
        step();
        flush_i = 1'b0;
        checks++; if (rom_addr !== 32'h20 || id_pc !== 32'h0 || id_inst !== 32'h0) begin errors++; $display("[TB] FAIL flush got %h %h/%h exp 00000020 0/0", rom_addr, id_pc, id_inst); end
        stall_if = 1'b0; stall_id = 1'b0;
        step();
        checks++; if (rom_addr !== 32'h24 || id_pc !== 32'h20 || id_inst !== 32'h1000_0008) begin errors++; $display("[TB] FAIL flush_drop_pend got %h %h/%h exp 00000024 00000020/10000008", rom_addr, id_pc, id_inst); end
    endtask

    task automatic test_wrap();
        do_reset();
        flush_i = 1'b1; new_pc_i = 32'hFFFF_FFFB;
        step();
        flush_i = 1'b0;
        checks++; if (rom_addr !== 32'hFFFF_FFF8) begin errors++; $display("[TB] FAIL wrap_load got %h exp fffffff8", rom_addr); end
        step();
        checks++; if (rom_addr !== 32'hFFFF_FFFC || id_pc !== 32'hFFFF_FFF8) begin errors++; $display("[TB] FAIL wrap_fc got %h/%h exp fffffffc/fffffff8", rom_addr, id_pc); end
        step();
        checks++; if (rom_addr !== 32'h0 || id_pc !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_zero got %h/%h exp 00000000/fffffffc", rom_addr, id_pc); end
    endtask

    task automatic test_reset_pending();
        do_reset();
        for (int k = 0; k < 4; k++) step();
        stall_if = 1'b1; stall_id = 1'b1; branch_flag_i = 1'b1; branch_target_i = 32'h80;
        step();
        branch_flag_i = 1'b0; rst = 1'b1;
        step();
        checks++; if (rom_ce !== 1'b0 || rom_addr !== 32'h0 || id_pc !== 32'h0 || id_inst !== 32'h0) begin errors++; $display("[TB] FAIL rst_mid_stall got ce=%b %h %h/%h exp ce=0 0 0/0", rom_ce, rom_addr, id_pc, id_inst); end
        rst = 1'b0; stall_if = 1'b0; stall_id = 1'b0;
        step();
        step();
        checks++; if (rom_addr !== 32'h4 || id_pc !== 32'h0 || id_inst !== 32'h1000_0000) begin errors++; $display("[TB] FAIL rst_pend_cleared got %h %h/%h exp 00000004 0/10000000", rom_addr, id_pc, id_inst); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_stall();
        test_branch_during_stall();
        test_flush();
        test_wrap();
        test_reset_pending();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
